// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared Game-of-Life grid geometry, scheduler states and bank ids
//
// Purpose: constants and types shared by the Game-of-Life engine blocks.
//   Y_SIZE/X_SIZE   grid dimensions in cells
//   Y_WIDTH/X_WIDTH address widths for rows/columns
//   GEN_WIDTH       generation counter width
//   sched_state_e   3-bit generation scheduler state encoding
//   BANK_A/BANK_B   ping-pong BRAM bank ids as seen on disp_sel
package gol_pkg;

    localparam int Y_SIZE    = 720;
    localparam int X_SIZE    = 1280;
    localparam int Y_WIDTH   = $clog2(Y_SIZE);
    localparam int X_WIDTH   = $clog2(X_SIZE);
    localparam int GEN_WIDTH = 32;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_HOLD      = 3'd2,
        ST_CALC      = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_SWAP_WAIT = 3'd5
    } sched_state_e;

    function automatic logic is_last_row(input logic [Y_WIDTH-1:0] row);
        return row == Y_WIDTH'(Y_SIZE - 1);
    endfunction

endpackage

// File: rtl/generation_scheduler_if.sv
// rtl/generation_scheduler_if.sv - signal bundle between the scheduler and its engine peers
//
// Purpose: groups the load/calc/video handshake signals of generation_scheduler.
//   slave  modport: the scheduler (consumes requests/status, drives control)
//   master modport: the surrounding engine (regfile, line_buffer, writer, video)
interface generation_scheduler_if;
    import gol_pkg::*;

    logic                 init_start;
    logic                 init_row_valid;
    logic                 pause;
    logic                 step;
    logic                 frame_end;
    logic                 row_valid;
    logic                 wr_en;
    logic [Y_WIDTH-1:0]   wr_addr;

    logic                 init_we;
    logic [Y_WIDTH-1:0]   init_row;
    logic                 init_ack;
    logic                 calc_flag;
    logic [Y_WIDTH-1:0]   calc_row;
    logic                 disp_sel;
    logic [GEN_WIDTH-1:0] gen_count;
    logic                 busy;

    modport slave (
        input  init_start, init_row_valid, pause, step, frame_end,
               row_valid, wr_en, wr_addr,
        output init_we, init_row, init_ack, calc_flag, calc_row,
               disp_sel, gen_count, busy
    );

    modport master (
        output init_start, init_row_valid, pause, step, frame_end,
               row_valid, wr_en, wr_addr,
        input  init_we, init_row, init_ack, calc_flag, calc_row,
               disp_sel, gen_count, busy
    );

endinterface

// File: rtl/generation_scheduler.sv
// rtl/generation_scheduler.sv - sequences grid load, per-generation calc passes and bank swaps
//
// Purpose: loads the initial grid row by row, runs one calc pass per generation over the
//   ping-pong banks and swaps the display bank only on a video frame boundary.
// Ports:
//   out_stream_aclk  sole clock
//   periph_reset     asynchronous active-high reset
//   sif (slave)      init_start/init_row_valid/pause/step/frame_end/row_valid/wr_en/wr_addr in;
//                    init_we/init_row/init_ack/calc_flag/calc_row/disp_sel/gen_count/busy out
module generation_scheduler
    import gol_pkg::*;
(
    input  logic                   out_stream_aclk,
    input  logic                   periph_reset,
    generation_scheduler_if.slave  sif
);

    sched_state_e         state_q, state_d;
    logic [Y_WIDTH-1:0]   row_q, row_d;
    logic                 disp_sel_q, disp_sel_d;
    logic [GEN_WIDTH-1:0] gen_q, gen_d;
    logic                 init_start_q;
    logic                 init_we_q, init_we_d;
    logic                 init_ack_q, init_ack_d;
    logic                 calc_flag_q, calc_flag_d;
    logic                 wr_last_q, wr_last_d;

    logic init_rise;
    logic last_wr;

    // init_start_q resets high so a level already present out of reset is not an edge.
    assign init_rise = sif.init_start & ~init_start_q;
    assign last_wr   = sif.wr_en & is_last_row(sif.wr_addr);

    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            disp_sel_q   <= BANK_A;
            gen_q        <= '0;
            init_start_q <= 1'b1;
            init_we_q    <= 1'b0;
            init_ack_q   <= 1'b0;
            calc_flag_q  <= 1'b0;
            wr_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            disp_sel_q   <= disp_sel_d;
            gen_q        <= gen_d;
            init_start_q <= sif.init_start;
            init_we_q    <= init_we_d;
            init_ack_q   <= init_ack_d;
            calc_flag_q  <= calc_flag_d;
            wr_last_q    <= wr_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        disp_sel_d  = disp_sel_q;
        gen_d       = gen_q;
        init_we_d   = 1'b0;
        init_ack_d  = 1'b0;
        calc_flag_d = calc_flag_q;
        wr_last_d   = 1'b0;

        if (init_rise && state_q != ST_IDLE && state_q != ST_LOAD && state_q != ST_HOLD &&
            state_q != ST_CALC && state_q != ST_DRAIN && state_q != ST_SWAP_WAIT) begin
            state_d     = ST_IDLE;
            row_d       = '0;
            calc_flag_d = 1'b0;
        end else if (init_rise) begin
            // A fresh load aborts whatever is running; the display bank is left alone.
            state_d     = ST_LOAD;
            row_d       = '0;
            calc_flag_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_LOAD: begin
                    // Row write happens the cycle after the valid pulse; the ack and the
                    // row advance follow one cycle later.
                    if (init_we_q) begin
                        init_ack_d = 1'b1;
                        if (is_last_row(row_q)) begin
                            row_d   = '0;
                            gen_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else if (sif.init_row_valid) begin
                        init_we_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!sif.pause || sif.step) begin
                        state_d     = ST_CALC;
                        row_d       = '0;
                        calc_flag_d = 1'b1;
                    end
                end
                ST_CALC: begin
                    if (sif.row_valid) begin
                        if (is_last_row(row_q)) begin
                            row_d       = '0;
                            calc_flag_d = 1'b0;
                            state_d     = ST_DRAIN;
                            // The writer may already deliver its final row this cycle.
                            wr_last_d   = last_wr;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wr_last_q || last_wr) begin
                        state_d = ST_SWAP_WAIT;
                    end
                end
                ST_SWAP_WAIT: begin
                    // frame_end is only looked at here, so one that coincides with the
                    // drain exit waits for the following frame.
                    if (sif.frame_end) begin
                        disp_sel_d = (disp_sel_q == BANK_A) ? BANK_B : BANK_A;
                        gen_d      = gen_q + 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    row_d       = '0;
                    calc_flag_d = 1'b0;
                end
            endcase
        end
    end

    assign sif.init_we   = init_we_q;
    assign sif.init_row  = (state_q == ST_LOAD) ? row_q : '0;
    assign sif.init_ack  = init_ack_q;
    assign sif.calc_flag = calc_flag_q;
    assign sif.calc_row  = (state_q == ST_CALC) ? row_q : '0;
    assign sif.disp_sel  = disp_sel_q;
    assign sif.gen_count = gen_q;
    assign sif.busy      = (state_q != ST_IDLE) && (state_q != ST_HOLD);

endmodule

// File: tb/tb_generation_scheduler.sv
// tb/tb_generation_scheduler.sv - directed self-checking bench for generation_scheduler
module tb_generation_scheduler;
    import gol_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    generation_scheduler_if sif();

    generation_scheduler dut (
        .out_stream_aclk (clk),
        .periph_reset    (rst),
        .sif             (sif)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Written by the stimulus process, read by the peer model.
    logic fe_main       = 1'b0;
    logic fe_on_last_wr = 1'b0;
    // Written by the peer model only.
    int   rows_seen = 0;
    int   row_err   = 0;
    int   fe_hits   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // line_buffer + writer model: row_valid every 3 cycles while calc_flag is high,
    // writer echoes the accepted row on wr_en/wr_addr two cycles later.
    initial begin
        int                 cnt;
        logic               prev_cf, d0v, d1v;
        logic [Y_WIDTH-1:0] d0a, d1a;
        cnt = 0; prev_cf = 1'b0; d0v = 1'b0; d1v = 1'b0; d0a = '0; d1a = '0;
        sif.row_valid = 1'b0;
        sif.wr_en     = 1'b0;
        sif.wr_addr   = '0;
        sif.frame_end = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            sif.wr_en   = d1v;
            sif.wr_addr = d1a;
            if (fe_on_last_wr && d1v && d1a == Y_WIDTH'(Y_SIZE - 1)) begin
                sif.frame_end = 1'b1;
                fe_hits++;
            end else begin
                sif.frame_end = fe_main;
            end
            d1v = d0v; d1a = d0a; d0v = 1'b0;
            sif.row_valid = 1'b0;
            if (sif.calc_flag && !prev_cf) begin
                rows_seen = 0; row_err = 0; cnt = 0;
            end
            if (sif.calc_flag) begin
                cnt++;
                if (cnt == 3) begin
                    cnt = 0;
                    sif.row_valid = 1'b1;
                    if (sif.calc_row !== Y_WIDTH'(rows_seen)) row_err++;
                    rows_seen++;
                    d0v = 1'b1;
                    d0a = sif.calc_row;
                end
            end else begin
                cnt = 0;
            end
            prev_cf = sif.calc_flag;
        end
    end

    task automatic load_grid(output int bad);
        bad = 0;
        for (int i = 0; i < Y_SIZE; i++) begin
            sif.init_row_valid = 1'b1;
            @(negedge clk);
            sif.init_row_valid = 1'b0;
            if (!(sif.init_we === 1'b1 && sif.init_row === Y_WIDTH'(i))) bad++;
            @(negedge clk);
            if (!(sif.init_ack === 1'b1 && sif.init_we === 1'b0)) bad++;
        end
    endtask

    task automatic wait_calc_done(input string tag);
        for (int n = 0; n < 3000 && sif.calc_flag; n++) @(negedge clk);
        check(tag, {31'd0, sif.calc_flag}, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic pulse_step;
        sif.step = 1'b1;
        @(negedge clk);
        sif.step = 1'b0;
    endtask

    // Frame boundary: disp_sel must hold this cycle and change on the next one.
    task automatic frame_swap(input string tag, input logic exp_disp, input int exp_gen);
        fe_main = 1'b1;
        check({tag, "_disp_before"}, {31'd0, sif.disp_sel}, {31'd0, ~exp_disp});
        @(negedge clk);
        fe_main = 1'b0;
        check({tag, "_disp_after"}, {31'd0, sif.disp_sel}, {31'd0, exp_disp});
        check({tag, "_gen"}, sif.gen_count, exp_gen);
        check({tag, "_hold"}, {31'd0, sif.busy}, 32'd0);
    endtask

    initial begin
        int bad;
        sif.init_start     = 1'b0;
        sif.init_row_valid = 1'b0;
        sif.pause          = 1'b1;
        sif.step           = 1'b0;

        // Reset state
        idle_cycles(3);
        check("rst_busy", {31'd0, sif.busy}, 32'd0);
        check("rst_disp", {31'd0, sif.disp_sel}, 32'd0);
        check("rst_gen", sif.gen_count, 32'd0);
        check("rst_calc_flag", {31'd0, sif.calc_flag}, 32'd0);
        check("rst_init_we", {31'd0, sif.init_we}, 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // 1: grid load
        sif.init_start = 1'b1;
        @(negedge clk);
        check("load_busy", {31'd0, sif.busy}, 32'd1);
        load_grid(bad);
        check("load_rows", bad, 32'd0);
        check("load_hold", {31'd0, sif.busy}, 32'd0);
        check("load_disp", {31'd0, sif.disp_sel}, 32'd0);
        sif.init_row_valid = 1'b1;
        @(negedge clk);
        sif.init_row_valid = 1'b0;
        check("hold_ignores_row_valid", {31'd0, sif.init_we}, 32'd0);

        // 2: free-running generation, pause raised mid-pass
        sif.pause = 1'b0;
        @(negedge clk);
        check("calc_start_flag", {31'd0, sif.calc_flag}, 32'd1);
        check("calc_start_row", {22'd0, sif.calc_row}, 32'd0);
        for (int n = 0; n < 2000 && rows_seen < 360; n++) @(negedge clk);
        sif.pause = 1'b1;
        wait_calc_done("g1_done");
        check("g1_rows", rows_seen, Y_SIZE);
        check("g1_row_seq", row_err, 32'd0);
        idle_cycles(6);
        check("g1_swap_wait", {31'd0, sif.busy}, 32'd1);
        check("g1_gen_pending", sif.gen_count, 32'd0);
        frame_swap("g1", 1'b1, 1);

        // 3: single step while paused; a second step mid-pass is ignored
        idle_cycles(10);
        check("paused_hold", {31'd0, sif.calc_flag}, 32'd0);
        pulse_step();
        check("step_calc", {31'd0, sif.calc_flag}, 32'd1);
        for (int n = 0; n < 2000 && rows_seen < 100; n++) @(negedge clk);
        pulse_step();
        wait_calc_done("g2_done");
        check("g2_rows", rows_seen, Y_SIZE);
        idle_cycles(6);
        frame_swap("g2", 1'b0, 2);
        idle_cycles(20);
        check("g2_single_gen", {31'd0, sif.calc_flag}, 32'd0);

        // 4: frame_end coinciding with the final write does not swap
        fe_on_last_wr = 1'b1;
        pulse_step();
        wait_calc_done("g3_done");
        idle_cycles(6);
        fe_on_last_wr = 1'b0;
        check("g3_fe_coincided", fe_hits, 32'd1);
        check("g3_no_early_swap", {31'd0, sif.disp_sel}, 32'd0);
        check("g3_still_waiting", {31'd0, sif.busy}, 32'd1);
        frame_swap("g3", 1'b1, 3);

        // 5: asynchronous reset mid-pass
        pulse_step();
        for (int n = 0; n < 2000 && sif.calc_row != Y_WIDTH'(300); n++) @(negedge clk);
        check("g4_reached_300", {22'd0, sif.calc_row}, 32'd300);
        #2 rst = 1'b1;
        #1;
        check("arst_calc_flag", {31'd0, sif.calc_flag}, 32'd0);
        check("arst_calc_row", {22'd0, sif.calc_row}, 32'd0);
        check("arst_disp", {31'd0, sif.disp_sel}, 32'd0);
        check("arst_gen", sif.gen_count, 32'd0);
        check("arst_busy", {31'd0, sif.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sif.pause = 1'b0;
        idle_cycles(5);
        check("idle_held_start", {31'd0, sif.busy}, 32'd0);
        check("idle_no_calc", {31'd0, sif.calc_flag}, 32'd0);
        sif.init_row_valid = 1'b1;
        @(negedge clk);
        sif.init_row_valid = 1'b0;
        check("idle_ignores_row_valid", {31'd0, sif.init_we}, 32'd0);
        sif.pause = 1'b1;
        sif.init_start = 1'b0;
        @(negedge clk);
        sif.init_start = 1'b1;
        @(negedge clk);
        check("reload_busy", {31'd0, sif.busy}, 32'd1);
        load_grid(bad);
        check("reload_rows", bad, 32'd0);
        check("reload_gen", sif.gen_count, 32'd0);

        // 6: init_start re-edge during CALC restarts the load, disp_sel retained
        pulse_step();
        wait_calc_done("g5_done");
        idle_cycles(6);
        frame_swap("g5", 1'b1, 1);
        pulse_step();
        for (int n = 0; n < 2000 && rows_seen < 50; n++) @(negedge clk);
        sif.init_start = 1'b0;
        @(negedge clk);
        sif.init_start = 1'b1;
        @(negedge clk);
        check("restart_calc_flag", {31'd0, sif.calc_flag}, 32'd0);
        check("restart_busy", {31'd0, sif.busy}, 32'd1);
        check("restart_disp", {31'd0, sif.disp_sel}, 32'd1);
        sif.init_row_valid = 1'b1;
        @(negedge clk);
        sif.init_row_valid = 1'b0;
        check("restart_we", {31'd0, sif.init_we}, 32'd1);
        check("restart_row0", {22'd0, sif.init_row}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
